mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and sequencer that shares one small synchronous memory between `N_REQ` requesters. Each requester issues single read or write transactions with a req/gnt handshake. The block drives the memory's separate read/write strobes one transaction at a time, never both together, and returns read data or write completion to the owning requester. It sits between the requester logic and the memory array.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..8).
- `DATA_W`, 4: memory word width.
- `ADDR_W`, 2: memory address width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  N_REQ  per-requester transaction request; held until granted.
- `we`  in  N_REQ  per-requester type; 1 = write, 0 = read; valid while `req` is high.
- `addr`  in  N_REQ×ADDR_W  per-requester address (unpacked array).
- `wdata`  in  N_REQ×DATA_W  per-requester write data (unpacked array).
- `gnt`  out  N_REQ  one-hot grant; the transaction is accepted on an edge where `req[i] & gnt[i]`.
- `done`  out  N_REQ  one-cycle completion pulse to the owner.
- `rdata`  out  DATA_W  read result; valid only while `done[i]` is high for a read.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; registered by the memory on the edge that samples `mem_read`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `gnt` is combinational: one-hot to the first requesting index at or after the priority pointer, wrapping modulo `N_REQ`.
  - `gnt` is 0 when no `req` is high, and 0 in every other state.
  - On accept, register the owner index, `we`, `addr`, and `wdata`, then go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `mem_addr` = the latched address.
  - `mem_read` = !we_latched; `mem_write` = we_latched; `mem_wdata` = the latched data.
  - Next state: WAIT for a read, RESP for a write.
- **WAIT** (reads only, 1 cycle)
  - Strobes are 0.
  - `mem_rdata` is now valid; capture it into the `rdata` register at the end of the cycle.
  - Next state: RESP.
- **RESP** (1 cycle)
  - `done[owner]` = 1; `rdata` holds the captured value.
  - The priority pointer becomes (owner+1) mod `N_REQ`.
  - Next state: IDLE.
- `mem_read & mem_write` is never 1. The illegal "both" memory configuration is therefore unreachable; an assertion in the bench checks this.
- `rdata` holds its last captured value until the next read capture. It is undefined for writes; the bench checks it only on read `done`.
- A requester dropping `req` before it is granted withdraws the request; no penalty.
- `req` changes on a non-granted requester have no effect on the transaction in flight.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE, priority pointer 0;
  - `gnt`=0 during reset;
  - `done`=0, `rdata`=0;
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-transaction drops the transaction with no `done`. A write in ISSUE when reset is sampled may or may not land in the memory; the bench does not check this.
- Latency is counted from the accept edge t:
  - write: `mem_write` in cycle t+1, `done` in cycle t+2;
  - read: `mem_read` in cycle t+1, `mem_rdata` sampled at end of t+2, `done`/`rdata` in cycle t+3.
- Next grant is possible in the cycle after RESP.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- Simultaneous requests: the pointer decides. With the pointer at 0 and all requesting, 0 is served, then 1, … `N_REQ-1`, then 0.
- Starvation bound: a held request is granted within `N_REQ-1` other transactions.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, WAIT, RESP};
  - constants for the ISSUE/WAIT cycle counts used by the bench.
- Sub-module `rr_arbiter`:
  - combinational one-hot pick from a `req` vector and the pointer;
  - a registered pointer with an update-enable;
  - reused wherever the design shares a resource.
- Top level: FSM, latch registers, memory-port drive.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with all `req`=1 → `gnt`=0, `done`=0, strobes 0, `rdata`=0 throughout.
- Single write then read: req0 writes 4'hA to addr 2, then reads addr 2 →
  - `mem_write` exactly at t+1 with addr 2, data A; `done[0]` at t+2;
  - read `done[0]` at t+3 with `rdata`=4'hA.
- Contention (`N_REQ`=2): req0 and req1 both held from reset release →
  - grant order 0,1,0,1 over 4 transactions;
  - `gnt` is never high outside IDLE;
  - `mem_read&mem_write` is never 1.
- Interleaved data: req0 writes 3 to addr 1 while req1 concurrently waits to read addr 1 → req1 `rdata`=3, served after req0's write completes.
- Reset mid-read: assert `rst_n`=0 during WAIT →
  - no `done` pulse; pointer returns to 0;
  - the next read of the same address completes normally.
- Withdrawn request: req1 raised for 1 cycle while req0's transaction is in flight, then dropped → req1 is never granted; `done[1]` stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and timing constants for the memory arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Cycles spent strobing the memory, and waiting for registered read data.
  localparam int ISSUE_CYCLES = 1;
  localparam int WAIT_CYCLES  = 1;

  // Cycles from the accept edge to the done pulse.
  localparam int WRITE_LATENCY = 1 + ISSUE_CYCLES;
  localparam int READ_LATENCY  = 1 + ISSUE_CYCLES + WAIT_CYCLES;

  // Index width for a requester count, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker with a registered priority pointer.
// The pointer moves to one past the last served index when update_en is high.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          update_en,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any,
  output logic [IW-1:0] ptr
);

  int idx;

  // Scan from the pointer upward, wrapping, and take the first request seen.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update_en) begin
      ptr <= (last_idx == IW'(N - 1)) ? '0 : last_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between N_REQ requesters, one transaction at a time.
// Handshake: a transaction is accepted on a rising edge where req[i] & gnt[i]; done[i] pulses once on completion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  we,
  input  logic [ADDR_W-1:0] addr  [N_REQ],
  input  logic [DATA_W-1:0] wdata [N_REQ],
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state,
  output logic [idx_w(N_REQ)-1:0] dbg_ptr
);

  localparam int IW = idx_w(N_REQ);

  arb_state_t       state;
  logic [IW-1:0]    owner;
  logic             we_q;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             accept;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .update_en (state == RESP),
    .last_idx  (owner),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .any       (pick_any),
    .ptr       (dbg_ptr)
  );

  // Grants are only offered while idle and out of reset.
  assign gnt       = (rst_n && state == IDLE) ? pick_gnt : '0;
  assign accept    = (state == IDLE) && pick_any;
  assign dbg_state = state;

  // mem_addr / mem_wdata double as the latched address and data of the owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      we_q      <= 1'b0;
      done      <= '0;
      rdata     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done      <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner     <= pick_idx;
            we_q      <= we[pick_idx];
            mem_read  <= !we[pick_idx];
            mem_write <= we[pick_idx];
            mem_addr  <= addr[pick_idx];
            mem_wdata <= wdata[pick_idx];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            done[owner] <= 1'b1;
            state       <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // The memory registered its output on the ISSUE edge; take it now.
          rdata       <= mem_rdata;
          done[owner] <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus hand-written
// sequences for contention, interleaving, reset during a read and a withdrawn request.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] we;
  logic [1:0] addr  [2];
  logic [3:0] wdata [2];
  logic [1:0] gnt;
  logic [1:0] done;
  logic [3:0] rdata;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic [1:0] dbg_state;
  logic [0:0] dbg_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.N_REQ(2), .DATA_W(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [3:0] mem_m [4];
  initial begin
    for (int i = 0; i < 4; i++) mem_m[i] = 4'h0;
    mem_rdata = 4'h0;
  end
  always @(posedge clk) begin
    if (mem_write) mem_m[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem_m[mem_addr];
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((mem_read & mem_write) !== 1'b0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL strobe_excl: read=%b write=%b", mem_read, mem_write);
      end
      if (dbg_state !== 2'd0 && gnt !== 2'b00) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL gnt_outside_idle: gnt=%b state=%0d", gnt, dbg_state);
      end
      if (!$onehot0(done)) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL done_onehot: done=%b", done);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Runs one isolated transaction and checks cycle-exact latency and data.
  task automatic do_txn(input int r, input logic w, input logic [1:0] a,
                        input logic [3:0] d, input logic [3:0] exp_rd);
    int waitc;
    logic [1:0] onehot;
    onehot = 2'b01 << r;
    waitc  = 0;
    we[r] = w; addr[r] = a; wdata[r] = d; req[r] = 1'b1;
    #1;
    while (gnt !== onehot && waitc < 20) begin
      tick();
      waitc++;
    end
    check("txn_grant", gnt, onehot);
    tick();
    req[r] = 1'b0;
    check("txn_issue_write", mem_write, w);
    check("txn_issue_read", mem_read, !w);
    check("txn_issue_addr", mem_addr, a);
    if (w) check("txn_issue_wdata", mem_wdata, d);
    check("txn_issue_nognt", gnt, 2'b00);
    tick();
    if (!w) begin
      check("txn_wait_strobes", {mem_read, mem_write}, 2'b00);
      check("txn_wait_nodone", done, 2'b00);
      tick();
    end
    check("txn_done", done, onehot);
    if (!w) check("txn_rdata", rdata, exp_rd);
    tick();
    check("txn_done_single", done, 2'b00);
  endtask

  typedef struct {
    int         r;
    logic       w;
    logic [1:0] a;
    logic [3:0] d;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs [8];
  logic [1:0] exp_g;

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    we    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = 2'd0;
      wdata[i] = 4'h0;
    end

    // Reset held 3 cycles with both requesters asking.
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_gnt", gnt, 2'b00);
      check("rst_done", done, 2'b00);
      check("rst_strobes", {mem_read, mem_write}, 2'b00);
      check("rst_rdata", rdata, 4'h0);
      check("rst_mem_addr", mem_addr, 2'd0);
      check("rst_mem_wdata", mem_wdata, 4'h0);
    end
    req   = 2'b00;
    rst_n = 1'b1;
    tick();

    // Single transactions with hand-computed results.
    vecs[0] = '{r: 0, w: 1'b1, a: 2'd2, d: 4'hA, exp_rd: 4'h0};
    vecs[1] = '{r: 0, w: 1'b0, a: 2'd2, d: 4'h0, exp_rd: 4'hA};
    vecs[2] = '{r: 1, w: 1'b1, a: 2'd0, d: 4'h5, exp_rd: 4'h0};
    vecs[3] = '{r: 1, w: 1'b0, a: 2'd0, d: 4'h0, exp_rd: 4'h5};
    vecs[4] = '{r: 0, w: 1'b0, a: 2'd2, d: 4'h0, exp_rd: 4'hA};
    vecs[5] = '{r: 1, w: 1'b1, a: 2'd3, d: 4'hF, exp_rd: 4'h0};
    vecs[6] = '{r: 0, w: 1'b0, a: 2'd3, d: 4'h0, exp_rd: 4'hF};
    vecs[7] = '{r: 1, w: 1'b0, a: 2'd1, d: 4'h0, exp_rd: 4'h0};
    for (int v = 0; v < 8; v++)
      do_txn(vecs[v].r, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].exp_rd);

    // Contention from reset release: both reading, expect 0,1,0,1 back to back.
    rst_n = 1'b0;
    tick();
    tick();
    we = 2'b00; addr[0] = 2'd2; addr[1] = 2'd0; req = 2'b11;
    rst_n = 1'b1;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      check("cont_gnt", gnt, exp_g);
      tick();
      check("cont_issue_read", mem_read, 1'b1);
      tick();
      check("cont_wait_nodone", done, 2'b00);
      tick();
      check("cont_done", done, exp_g);
      check("cont_rdata", rdata, (t % 2 == 0) ? 4'hA : 4'h5);
      tick();
    end
    req = 2'b00;
    tick();

    // Interleaved: req0 writes 3 to addr 1 while req1 waits to read addr 1.
    we[0] = 1'b1; addr[0] = 2'd1; wdata[0] = 4'h3;
    we[1] = 1'b0; addr[1] = 2'd1;
    req = 2'b11;
    #1;
    check("inter_gnt0", gnt, 2'b01);
    tick();
    req[0] = 1'b0;
    check("inter_write", {mem_write, mem_addr, mem_wdata}, {1'b1, 2'd1, 4'h3});
    tick();
    check("inter_wdone", done, 2'b01);
    tick();
    check("inter_gnt1", gnt, 2'b10);
    tick();
    req[1] = 1'b0;
    check("inter_read", {mem_read, mem_addr}, {1'b1, 2'd1});
    tick();
    tick();
    check("inter_rdone", done, 2'b10);
    check("inter_rdata", rdata, 4'h3);
    tick();

    // Reset during WAIT: pointer first moved to 1 by a req0 transaction.
    do_txn(0, 1'b1, 2'd0, 4'h7, 4'h0);
    we[1] = 1'b0; addr[1] = 2'd1; req[1] = 1'b1;
    #1;
    check("midrst_gnt", gnt, 2'b10);
    tick();
    req[1] = 1'b0;
    check("midrst_issue", mem_read, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_nodone", done, 2'b00);
    check("midrst_strobes", {mem_read, mem_write}, 2'b00);
    rst_n = 1'b1;
    tick();
    check("midrst_nodone_after", done, 2'b00);
    we = 2'b00; addr[0] = 2'd1; addr[1] = 2'd1; req = 2'b11;
    #1;
    check("midrst_ptr_zero", gnt, 2'b01);
    req = 2'b00;
    tick();
    do_txn(1, 1'b0, 2'd1, 4'h0, 4'h3);

    // Withdrawn request: req1 pulses for one cycle while req0's read is in flight.
    we = 2'b00; addr[0] = 2'd2; req[0] = 1'b1;
    #1;
    check("wd_gnt0", gnt, 2'b01);
    tick();
    req[0] = 1'b0;
    req[1] = 1'b1;
    check("wd_issue_nognt", gnt, 2'b00);
    tick();
    req[1] = 1'b0;
    check("wd_wait_nognt", gnt, 2'b00);
    tick();
    check("wd_done0", done, 2'b01);
    check("wd_rdata", rdata, 4'hA);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("wd_no_gnt1", gnt, 2'b00);
      check("wd_no_done1", done, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
